decode_stage: RTL and testbench

- Decode stage of the 5-stage, 19-bit-datapath pipelined processor with 20-bit instructions.
- Decodes InstrD into control signals and reads two source operands from a 19-entry register file.
- Sign-extends the immediate and registers everything into the D/E pipeline register feeding Execute.
- Accepts writeback (RegWriteW/RdW/ResultW) from the W stage.

---
 rtl/decode_pkg.sv | 45 ++++
 rtl/decode_stage_if.sv | 34 +++
 rtl/decode_stage_regfile.sv | 28 ++
 rtl/decode_stage.sv | 114 +++++++++++
 tb/tb_decode_stage.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared widths, field positions and control encodings for the decode stage
package decode_pkg;
    localparam int DW     = 19;
    localparam int IW     = 20;
    localparam int PW     = 15;
    localparam int NREG   = 19;
    localparam int RW     = 5;
    localparam int OP_LO  = 0;
    localparam int OP_HI  = 4;
    localparam int RD_LO  = 5;
    localparam int RD_HI  = 9;
    localparam int RS1_LO = 10;
    localparam int RS1_HI = 14;
    localparam int RS2_LO = 15;
    localparam int RS2_HI = 19;
    typedef enum logic [1:0] {
        CLS_R   = 2'b00,
        CLS_I   = 2'b01,
        CLS_MEM = 2'b10,
        CLS_CTL = 2'b11
    } instrClass_e;
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_MUL = 3'b111
    } aluOp_e;
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10,
        BR_LT   = 2'b11
    } branch_e;
    localparam logic [2:0] CTL_JMP = 3'b000;
    function automatic logic [DW-1:0] sext5(input logic [4:0] v);
        return {{(DW-5){v[4]}}, v};
    endfunction
    function automatic logic [DW-1:0] sext15(input logic [14:0] v);
        return {{(DW-15){v[14]}}, v};
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: Decode-side inputs, W-stage writeback and the D/E register outputs
interface decode_stage_if;
    import decode_pkg::*;
    logic          RegWriteW;
    logic [IW-1:0] InstrD;
    logic [DW-1:0] ResultW;
    logic [PW-1:0] PCD;
    logic [RW-1:0] RdW;
    logic          RegWriteE;
    logic          MemWriteE;
    logic          JumpE;
    logic          ALUSrcE;
    logic          ResultSrcE;
    logic          Cant_ByteE;
    logic [1:0]    BranchE;
    logic [2:0]    ALUControlE;
    logic [DW-1:0] RD1E;
    logic [DW-1:0] RD2E;
    logic [DW-1:0] ImmExtE;
    logic [PW-1:0] PCE;
    logic [RW-1:0] RDE;
    logic [RW-1:0] RS1E;
    logic [RW-1:0] RS2E;
    modport master (
        output RegWriteW, InstrD, ResultW, PCD, RdW,
        input  RegWriteE, MemWriteE, JumpE, ALUSrcE, ResultSrcE, Cant_ByteE,
               BranchE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, RDE, RS1E, RS2E
    );
    modport slave (
        input  RegWriteW, InstrD, ResultW, PCD, RdW,
        output RegWriteE, MemWriteE, JumpE, ALUSrcE, ResultSrcE, Cant_ByteE,
               BranchE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, RDE, RS1E, RS2E
    );
endinterface

// File: rtl/decode_stage_regfile.sv
// register_file: 19x19 register file, falling-edge write, two combinational reads, R0 hardwired to 0
module register_file
    import decode_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [RW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [RW-1:0] ra1,
    input  logic [RW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2
);
    logic [DW-1:0] regs [NREG];

    // Write on the falling edge so the following rising edge already sees the new value
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != '0 && int'(wa) < NREG) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 != '0 && int'(ra1) < NREG) ? regs[ra1] : '0;
    assign rd2 = (ra2 != '0 && int'(ra2) < NREG) ? regs[ra2] : '0;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode, operand read and D/E pipeline register
module decode_stage
    import decode_pkg::*;
(
    input logic           clk,
    input logic           reset,
    decode_stage_if.slave bus
);
    logic [RW-1:0] rd, rs1, rs2;
    logic [2:0]    func;
    instrClass_e   cls;
    logic          regWrite, memWrite, jump, aluSrc, resultSrc, cantByte;
    branch_e       branch;
    aluOp_e        aluCtl;
    logic [DW-1:0] immExt, rd1, rd2;

    assign func = bus.InstrD[OP_HI-2:OP_LO];
    assign cls  = instrClass_e'(bus.InstrD[OP_HI:OP_HI-1]);
    assign rd   = bus.InstrD[RD_HI:RD_LO];
    assign rs1  = bus.InstrD[RS1_HI:RS1_LO];
    assign rs2  = bus.InstrD[RS2_HI:RS2_LO];

    register_file u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (bus.RegWriteW),
        .wa    (bus.RdW),
        .wd    (bus.ResultW),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Control decode and immediate selection; the rs2 and rd fields double as immediate sources
    always_comb begin
        regWrite  = 1'b0;
        memWrite  = 1'b0;
        jump      = 1'b0;
        aluSrc    = 1'b0;
        resultSrc = 1'b0;
        cantByte  = 1'b0;
        branch    = BR_NONE;
        aluCtl    = ALU_ADD;
        immExt    = '0;
        case (cls)
            CLS_R: begin
                regWrite = 1'b1;
                aluCtl   = aluOp_e'(func);
            end
            CLS_I: begin
                regWrite = 1'b1;
                aluSrc   = 1'b1;
                aluCtl   = aluOp_e'(func);
                immExt   = sext5(rs2);
            end
            CLS_MEM: begin
                aluSrc    = 1'b1;
                cantByte  = func[1];
                memWrite  = func[0];
                regWrite  = !func[0];
                resultSrc = !func[0];
                immExt    = func[0] ? sext5(rd) : sext5(rs2);
            end
            CLS_CTL: begin
                if (func == CTL_JMP) begin
                    jump   = 1'b1;
                    immExt = sext15(bus.InstrD[IW-1:RD_LO]);
                end else if (!func[2]) begin
                    branch = branch_e'(func[1:0]);
                    aluCtl = ALU_SUB;
                    immExt = sext5(rd);
                end
            end
        endcase
    end

    // D/E pipeline register; reset clears every output immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.RegWriteE   <= 1'b0;
            bus.MemWriteE   <= 1'b0;
            bus.JumpE       <= 1'b0;
            bus.ALUSrcE     <= 1'b0;
            bus.ResultSrcE  <= 1'b0;
            bus.Cant_ByteE  <= 1'b0;
            bus.BranchE     <= '0;
            bus.ALUControlE <= '0;
            bus.RD1E        <= '0;
            bus.RD2E        <= '0;
            bus.ImmExtE     <= '0;
            bus.PCE         <= '0;
            bus.RDE         <= '0;
            bus.RS1E        <= '0;
            bus.RS2E        <= '0;
        end else begin
            bus.RegWriteE   <= regWrite;
            bus.MemWriteE   <= memWrite;
            bus.JumpE       <= jump;
            bus.ALUSrcE     <= aluSrc;
            bus.ResultSrcE  <= resultSrc;
            bus.Cant_ByteE  <= cantByte;
            bus.BranchE     <= branch;
            bus.ALUControlE <= aluCtl;
            bus.RD1E        <= rd1;
            bus.RD2E        <= rd2;
            bus.ImmExtE     <= immExt;
            bus.PCE         <= bus.PCD;
            bus.RDE         <= rd;
            bus.RS1E        <= rs1;
            bus.RS2E        <= rs2;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed checks of decode_stage against a behavioural model
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int refRegs [32];
    int eRegWrite, eMemWrite, eJump, eAluSrc, eResultSrc, eCantByte;
    int eBranch, eAlu, eRd1, eRd2, eImm, ePc, eRd, eRs1, eRs2;

    always #5 clk = ~clk;

    decode_stage_if bus();
    decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v, input int bits);
        return ((v >= (1 << (bits - 1))) ? v - (1 << bits) : v) & 'h7FFFF;
    endfunction

    function automatic int rf(input int i);
        return (i >= 1 && i <= 18) ? refRegs[i] : 0;
    endfunction

    task automatic predict(input int ins, input int pc);
        int op, cls, func, rdF, rs1F, rs2F;
        op = ins % 32;
        cls = op / 8;
        func = op % 8;
        rdF = (ins / 32) % 32;
        rs1F = (ins / 1024) % 32;
        rs2F = (ins / 32768) % 32;
        {eRegWrite, eMemWrite, eJump, eAluSrc, eResultSrc, eCantByte} = '0;
        {eBranch, eAlu, eImm} = '0;
        eRd = rdF;
        eRs1 = rs1F;
        eRs2 = rs2F;
        eRd1 = rf(rs1F);
        eRd2 = rf(rs2F);
        ePc = pc;
        if (cls == 0) begin
            eRegWrite = 1;
            eAlu = func;
        end else if (cls == 1) begin
            eRegWrite = 1;
            eAluSrc = 1;
            eAlu = func;
            eImm = sx(rs2F, 5);
        end else if (cls == 2) begin
            eAluSrc = 1;
            eCantByte = (func / 2) % 2;
            if (func % 2 == 0) begin
                eRegWrite = 1;
                eResultSrc = 1;
                eImm = sx(rs2F, 5);
            end else begin
                eMemWrite = 1;
                eImm = sx(rdF, 5);
            end
        end else if (func == 0) begin
            eJump = 1;
            eImm = sx(ins / 32, 15);
        end else if (func < 4) begin
            eBranch = func;
            eAlu = 1;
            eImm = sx(rdF, 5);
        end
    endtask

    task automatic compareAll(input string t);
        check({t, ".RegWriteE"}, 32'(bus.RegWriteE), eRegWrite);
        check({t, ".MemWriteE"}, 32'(bus.MemWriteE), eMemWrite);
        check({t, ".JumpE"}, 32'(bus.JumpE), eJump);
        check({t, ".ALUSrcE"}, 32'(bus.ALUSrcE), eAluSrc);
        check({t, ".ResultSrcE"}, 32'(bus.ResultSrcE), eResultSrc);
        check({t, ".Cant_ByteE"}, 32'(bus.Cant_ByteE), eCantByte);
        check({t, ".BranchE"}, 32'(bus.BranchE), eBranch);
        check({t, ".ALUControlE"}, 32'(bus.ALUControlE), eAlu);
        check({t, ".RD1E"}, 32'(bus.RD1E), eRd1);
        check({t, ".RD2E"}, 32'(bus.RD2E), eRd2);
        check({t, ".ImmExtE"}, 32'(bus.ImmExtE), eImm);
        check({t, ".PCE"}, 32'(bus.PCE), ePc);
        check({t, ".RDE"}, 32'(bus.RDE), eRd);
        check({t, ".RS1E"}, 32'(bus.RS1E), eRs1);
        check({t, ".RS2E"}, 32'(bus.RS2E), eRs2);
    endtask

    task automatic checkZero(input string t);
        {eRegWrite, eMemWrite, eJump, eAluSrc, eResultSrc, eCantByte} = '0;
        {eBranch, eAlu, eRd1, eRd2, eImm, ePc, eRd, eRs1, eRs2} = '0;
        compareAll(t);
    endtask

    task automatic randomInputs();
        bus.InstrD = 20'($urandom);
        bus.PCD = 15'($urandom);
        bus.RegWriteW = 1'($urandom);
        bus.RdW = 5'($urandom);
        bus.ResultW = 19'($urandom);
    endtask

    task automatic step(input string t, input logic [19:0] ins, input logic [14:0] pc,
                        input logic we, input logic [4:0] rdw, input logic [18:0] res);
        bus.InstrD = ins;
        bus.PCD = pc;
        bus.RegWriteW = we;
        bus.RdW = rdw;
        bus.ResultW = res;
        if (we && rdw >= 1 && rdw <= 18) refRegs[rdw] = int'(res);
        predict(int'(ins), int'(pc));
        @(posedge clk);
        #1;
        compareAll(t);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) refRegs[i] = 0;
        randomInputs();
        repeat (3) @(posedge clk);
        #1;
        checkZero("rst_hold");
        randomInputs();
        @(posedge clk);
        #1;
        checkZero("rst_hold2");
        #1 reset = 1'b1;
        step("first", 20'h00429, 15'h5, 1'b0, 5'd0, 19'd0);
        check("first.ALUControlE_c", 32'(bus.ALUControlE), 1);
        check("first.PCE_c", 32'(bus.PCE), 'h5);
        step("wb", 20'h01429, 15'h0, 1'b1, 5'd5, 19'h5);
        check("wb.RD1E_c", 32'(bus.RD1E), 'h5);
        step("r0", 20'h00029, 15'h0, 1'b1, 5'd0, 19'h7FFFF);
        check("r0.RD1E_c", 32'(bus.RD1E), 0);
        step("nowe", 20'h01429, 15'h0, 1'b0, 5'd5, 19'h003FF);
        check("nowe.RD1E_c", 32'(bus.RD1E), 'h5);
        step("wr3", 20'h00000, 15'h0, 1'b1, 5'd3, 19'h01234);
        step("sb", 20'h183F3, 15'h10, 1'b0, 5'd0, 19'd0);
        check("sb.ImmExtE_c", 32'(bus.ImmExtE), 'h7FFFF);
        check("sb.RD2E_c", 32'(bus.RD2E), 'h1234);
        step("blt", 20'h0005B, 15'h11, 1'b0, 5'd0, 19'd0);
        check("blt.BranchE_c", 32'(bus.BranchE), 3);
        check("blt.ImmExtE_c", 32'(bus.ImmExtE), 2);
        step("jmp", 20'hFFFF8, 15'h12, 1'b0, 5'd0, 19'd0);
        check("jmp.ImmExtE_c", 32'(bus.ImmExtE), 'h7FFFF);
        for (int n = 0; n < 300; n++)
            step($sformatf("rnd%0d", n), 20'($urandom), 15'($urandom), 1'($urandom),
                 5'($urandom_range(0, 31)), 19'($urandom));
        step("wr5", 20'h00000, 15'h0, 1'b1, 5'd5, 19'h2AAAA);
        step("rd5", 20'h01429, 15'h0, 1'b0, 5'd0, 19'd0);
        #2;
        bus.RegWriteW = 1'b0;
        reset = 1'b0;
        #1;
        checkZero("midrst");
        for (int i = 0; i < 32; i++) refRegs[i] = 0;
        #1 reset = 1'b1;
        step("after", 20'h01429, 15'h7, 1'b0, 5'd0, 19'd0);
        check("after.RD1E_c", 32'(bus.RD1E), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
